// File: rtl/fc_wagu_param.sv
// Fully-connected weight address generator.
// For every output piece it walks all input pieces. Each loaded feature piece
// triggers GROUP_LEN sequential weight-buffer reads. Reads stall on wb_ready.
// One feature-load pulse may arrive early and is held in a pending latch.
// A second early pulse raises a sticky overflow flag.
module fc_wagu_param #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned PIECE_W   = 8,
  parameter int unsigned GROUP_LEN = 32,
  parameter int unsigned GCNT_W    = 6,
  parameter logic [3:0]  FC_MODE   = 4'd2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_calculate,
  input  logic               feature_load_end,
  input  logic               wb_ready,
  input  logic [3:0]         mode,
  input  logic [ADDR_W-1:0]  addr_start_w,
  input  logic [PIECE_W-1:0] in_piece,
  input  logic [PIECE_W-1:0] out_piece,
  output logic [ADDR_W-1:0]  o_w_addr,
  output logic               o_rd_en,
  output logic               o_group_end,
  output logic               o_fc_out,
  output logic               o_done,
  output logic               o_busy,
  output logic               o_err_ovf,
  output logic [2:0]         o_state,
  output logic [PIECE_W-1:0] o_piece,
  output logic [PIECE_W-1:0] o_out_cnt,
  output logic [GCNT_W-1:0]  o_group_cnt
);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWaitFeat = 3'd1,
    StRead     = 3'd2,
    StGend     = 3'd3
  } state_e;

  localparam logic [GCNT_W-1:0]  GcntLast = GCNT_W'(GROUP_LEN - 1);
  localparam logic [PIECE_W-1:0] PieceOne = PIECE_W'(1);
  localparam logic [ADDR_W-1:0]  AddrOne  = ADDR_W'(1);
  localparam logic [GCNT_W-1:0]  GcntOne  = GCNT_W'(1);

  state_e               state_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [GCNT_W-1:0]    group_cnt_q;
  logic [PIECE_W-1:0]   piece_q;
  logic [PIECE_W-1:0]   out_cnt_q;
  logic [PIECE_W-1:0]   in_piece_q;
  logic [PIECE_W-1:0]   out_piece_q;
  logic                 pend_q;
  logic                 err_ovf_q;
  logic                 group_end_q;
  logic                 fc_out_q;
  logic                 done_q;

  logic start_ok;
  logic rd_fire;
  logic last_read;
  logic last_piece;
  logic last_out;

  // Decode the current cycle's events from registered state and live inputs.
  always_comb begin
    start_ok   = start_calculate && (mode == FC_MODE) &&
                 (in_piece != '0) && (out_piece != '0);
    rd_fire    = (state_q == StRead) && wb_ready;
    last_read  = rd_fire && (group_cnt_q == GcntLast);
    last_piece = (piece_q == (in_piece_q - PieceOne));
    last_out   = (out_cnt_q == (out_piece_q - PieceOne));
  end

  // Main FSM with counters, pending latch and registered GEND pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      group_cnt_q <= '0;
      piece_q     <= '0;
      out_cnt_q   <= '0;
      in_piece_q  <= '0;
      out_piece_q <= '0;
      pend_q      <= 1'b0;
      err_ovf_q   <= 1'b0;
      group_end_q <= 1'b0;
      fc_out_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // Pulses live for the single GEND cycle only.
      group_end_q <= 1'b0;
      fc_out_q    <= 1'b0;
      done_q      <= 1'b0;

      case (state_q)
        StIdle: begin
          if (start_ok) begin
            in_piece_q  <= in_piece;
            out_piece_q <= out_piece;
            addr_q      <= addr_start_w;
            group_cnt_q <= '0;
            piece_q     <= '0;
            out_cnt_q   <= '0;
            pend_q      <= 1'b0;
            state_q     <= StWaitFeat;
          end
        end

        StWaitFeat: begin
          if (feature_load_end || pend_q) begin
            pend_q  <= 1'b0;
            state_q <= StRead;
          end
        end

        StRead: begin
          // An early feature pulse is remembered; a second one is an overflow.
          if (feature_load_end) begin
            if (pend_q) begin
              err_ovf_q <= 1'b1;
            end
            pend_q <= 1'b1;
          end
          if (rd_fire) begin
            addr_q <= addr_q + AddrOne;
            if (last_read) begin
              group_cnt_q <= '0;
              state_q     <= StGend;
              // Piece counters are still those of the group just finished.
              group_end_q <= 1'b1;
              fc_out_q    <= last_piece;
              done_q      <= last_piece && last_out;
            end else begin
              group_cnt_q <= group_cnt_q + GcntOne;
            end
          end
        end

        StGend: begin
          if (last_piece && last_out) begin
            // Layer finished: park counters at zero.
            piece_q   <= '0;
            out_cnt_q <= '0;
            pend_q    <= 1'b0;
            state_q   <= StIdle;
          end else begin
            if (last_piece) begin
              piece_q   <= '0;
              out_cnt_q <= out_cnt_q + PieceOne;
            end else begin
              piece_q <= piece_q + PieceOne;
            end
            if (pend_q || feature_load_end) begin
              // One request is consumed; if both were present one stays pending.
              pend_q  <= pend_q && feature_load_end;
              state_q <= StRead;
            end else begin
              state_q <= StWaitFeat;
            end
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Drive outputs from the registers; only the read strobe sees wb_ready.
  always_comb begin
    o_w_addr    = addr_q;
    o_rd_en     = rd_fire;
    o_group_end = group_end_q;
    o_fc_out    = fc_out_q;
    o_done      = done_q;
    o_busy      = (state_q != StIdle);
    o_err_ovf   = err_ovf_q;
    o_state     = state_q;
    o_piece     = piece_q;
    o_out_cnt   = out_cnt_q;
    o_group_cnt = group_cnt_q;
  end

endmodule
